// File: rtl/mux_scan_nto1.sv
// N-to-1 registered channel mux with manual select and an automatic scan mode.
// Each channel is held for dwell+1 cycles and wrap pulses when a sweep completes.
module mux_scan_nto1 #(
  parameter int N_CH    = 5,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    data,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               hold,
  output logic               data_out,
  output logic [SEL_W-1:0]   sel_out,
  output logic               valid,
  output logic               wrap
);

  typedef enum logic {MANUAL, SCAN} state_t;

  localparam int unsigned      N_SLOTS  = 2**SEL_W;
  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST     = SEL_W'(N_CH-1);

  state_t             state, state_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               wrap_nxt;
  logic               valid_nxt;
  logic               data_nxt;
  logic               sel_ok;
  logic [N_SLOTS-1:0] data_pad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MANUAL;
      sel_out  <= '0;
      cnt      <= '0;
      data_out <= 1'b0;
      valid    <= 1'b1;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel_out  <= sel_nxt;
      cnt      <= cnt_nxt;
      data_out <= data_nxt;
      valid    <= valid_nxt;
      wrap     <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = mode ? SCAN : MANUAL;
    sel_nxt   = sel_out;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    sel_ok    = ({1'b0, sel_out} < N_CH_EXT);

    // Action is chosen by the state being registered, so the edge that
    // enters MANUAL already loads sel_in and the entry edge into SCAN only
    // sanitises the start index.
    if (!mode) begin
      sel_nxt = sel_in;
      cnt_nxt = '0;
    end else if (state == MANUAL) begin
      sel_nxt = sel_ok ? sel_out : '0;
      cnt_nxt = '0;
    end else if (!hold) begin
      if (cnt >= dwell) begin
        cnt_nxt = '0;
        if (sel_out == LAST) begin
          sel_nxt  = '0;
          wrap_nxt = 1'b1;
        end else if (!sel_ok) begin
          sel_nxt = '0;
        end else begin
          sel_nxt = sel_out + SEL_W'(1);
        end
      end else begin
        cnt_nxt = cnt + DWELL_W'(1);
      end
    end

    // Unused slots read as 0, so out-of-range indices yield data_out = 0.
    data_pad           = '0;
    data_pad[N_CH-1:0] = data;
    valid_nxt          = ({1'b0, sel_nxt} < N_CH_EXT);
    data_nxt           = data_pad[sel_nxt] & valid_nxt;
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed bench for mux_scan_nto1: manual select table plus scan, hold,
// reset, mode-switch and dwell-change sequences.
module tb_mux_scan_nto1;

  logic       clk;
  logic       rst;
  logic [4:0] data;
  logic       mode;
  logic [2:0] sel_in;
  logic [3:0] dwell;
  logic       hold;
  logic       data_out;
  logic [2:0] sel_out;
  logic       valid;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  mux_scan_nto1 #(.N_CH(5), .SEL_W(3), .DWELL_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .mode     (mode),
    .sel_in   (sel_in),
    .dwell    (dwell),
    .hold     (hold),
    .data_out (data_out),
    .sel_out  (sel_out),
    .valid    (valid),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [4:0] dat;
    logic       exp_d;
    logic       exp_v;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input int e_sel, input int e_d,
                            input int e_v, input int e_w);
    chk({name, ".sel_out"}, int'(sel_out), e_sel);
    chk({name, ".data_out"}, int'(data_out), e_d);
    chk({name, ".valid"}, int'(valid), e_v);
    chk({name, ".wrap"}, int'(wrap), e_w);
  endtask

  // k = edges since the SCAN entry edge, starting from channel 0.
  task automatic check_scan(input string name, input int k, input int d);
    int e_sel;
    int e_w;
    logic [4:0] dv;
    e_sel = (k / (d + 1)) % 5;
    e_w   = (k > 0 && (k % (5 * (d + 1))) == 0) ? 1 : 0;
    dv    = data;
    check_outs(name, e_sel, int'(dv[e_sel]), 1, e_w);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    mode   = 1'b0;
    sel_in = '0;
    hold   = 1'b0;
    tick();
    rst    = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd0, 5'b10110, 1'b0, 1'b1};
    vecs[1] = '{3'd1, 5'b10110, 1'b1, 1'b1};
    vecs[2] = '{3'd2, 5'b10110, 1'b1, 1'b1};
    vecs[3] = '{3'd3, 5'b10110, 1'b0, 1'b1};
    vecs[4] = '{3'd4, 5'b10110, 1'b1, 1'b1};
    vecs[5] = '{3'd5, 5'b10110, 1'b0, 1'b0};
    vecs[6] = '{3'd6, 5'b10110, 1'b0, 1'b0};
    vecs[7] = '{3'd7, 5'b11111, 1'b0, 1'b0};

    rst = 1'b1; mode = 1'b0; sel_in = '0; dwell = '0; hold = 1'b0; data = 5'b11111;
    tick();
    tick();
    check_outs("reset", 0, 0, 1, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sel_in = vecs[i].sel;
      data   = vecs[i].dat;
      tick();
      check_outs("manual", int'(vecs[i].sel), int'(vecs[i].exp_d), int'(vecs[i].exp_v), 0);
    end

    hold = 1'b1; sel_in = 3'd3; data = 5'b01000;
    tick();
    check_outs("manual_hold", 3, 1, 1, 0);
    hold = 1'b0;

    do_reset();
    data = 5'b01101; dwell = 4'd0; mode = 1'b1;
    tick();
    check_scan("scan_d0", 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_scan("scan_d0", k, 0);
    end

    do_reset();
    data = 5'b10101; dwell = 4'd2; mode = 1'b1;
    tick();
    check_scan("scan_d2", 0, 2);
    for (int k = 1; k <= 31; k++) begin
      tick();
      check_scan("scan_d2", k, 2);
    end

    do_reset();
    data = 5'b00000; dwell = 4'd2; mode = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) tick();
    check_outs("hold_pre", 2, 0, 1, 0);
    hold = 1'b1;
    for (int j = 0; j < 4; j++) begin
      data[2] = ~data[2];
      tick();
      check_outs("hold", 2, int'(data[2]), 1, 0);
    end
    hold = 1'b0;
    tick();
    chk("hold_rel1.sel_out", int'(sel_out), 2);
    tick();
    chk("hold_rel2.sel_out", int'(sel_out), 3);
    tick();
    tick();
    chk("hold_rel4.sel_out", int'(sel_out), 3);
    tick();
    chk("hold_rel5.sel_out", int'(sel_out), 4);

    do_reset();
    data = 5'b11111; dwell = 4'd0; mode = 1'b1;
    for (int k = 0; k <= 3; k++) tick();
    chk("rstmid_pre.sel_out", int'(sel_out), 3);
    rst = 1'b1;
    tick();
    check_outs("rstmid", 0, 0, 1, 0);
    rst = 1'b0;
    tick();
    check_outs("rstmid_entry", 0, 1, 1, 0);
    tick();
    check_outs("rstmid_1", 1, 1, 1, 0);
    tick();
    check_outs("rstmid_2", 2, 1, 1, 0);

    do_reset();
    data = 5'b01010; dwell = 4'd0; mode = 1'b1;
    for (int k = 0; k <= 3; k++) tick();
    chk("msw_pre.sel_out", int'(sel_out), 3);
    mode = 1'b0; sel_in = 3'd1;
    tick();
    check_outs("msw_man", 1, 1, 1, 0);
    mode = 1'b1; sel_in = 3'd4;
    tick();
    check_outs("msw_entry", 1, 1, 1, 0);
    tick();
    check_outs("msw_2", 2, 0, 1, 0);
    tick();
    check_outs("msw_3", 3, 1, 1, 0);
    tick();
    check_outs("msw_4", 4, 0, 1, 0);
    tick();
    check_outs("msw_wrap", 0, 0, 1, 1);

    do_reset();
    data = 5'b00111; dwell = 4'd5; mode = 1'b1;
    for (int k = 0; k <= 4; k++) tick();
    chk("dwchg_pre.sel_out", int'(sel_out), 0);
    dwell = 4'd2;
    tick();
    chk("dwchg_adv.sel_out", int'(sel_out), 1);
    tick();
    tick();
    chk("dwchg_hold.sel_out", int'(sel_out), 1);
    tick();
    chk("dwchg_next.sel_out", int'(sel_out), 2);

    do_reset();
    sel_in = 3'd6; data = 5'b11111;
    tick();
    check_outs("inv_man", 6, 0, 0, 0);
    mode = 1'b1;
    tick();
    check_outs("inv_entry", 0, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
